uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter clk_frequency, default 50000000, the clk frequency in Hz.
REQ-002 SHALL have parameter baud_rate, default 115200, the serial bit rate.
REQ-003 SHALL have parameter data_bits, default 8, the data bits per frame; legal range 5..9.
REQ-004 SHALL have parameter parity_mode, default 0, where 0 = none, 1 = even, 2 = odd.
REQ-005 SHALL have parameter stop_bits, default 1, the stop bits per frame; legal values 1..2.
REQ-006 SHALL have parameter fifo_depth, default 4, the number of receive FIFO entries; a power of 2, at least 2.
REQ-007 SHALL have port clk, input, 1 bit: the clock; all logic is clocked on its rising edge.
REQ-008 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-009 SHALL have port rx, input, 1 bit: serial line, idle high, asynchronous to clk.
REQ-010 SHALL have port out_data, output, data_bits: received data of the FIFO head entry.
REQ-011 SHALL have port out_parity_err, output, 1 bit: the parity-error flag of the head entry.
REQ-012 SHALL have port out_frame_err, output, 1 bit: the framing-error flag of the head entry.
REQ-013 SHALL have port out_valid, output, 1 bit: the FIFO is non-empty.
REQ-014 SHALL have port out_ready, input, 1 bit: the consumer accepts the head entry.
REQ-015 SHALL have port overrun, output, 1 bit: sticky flag, set when a frame was dropped.
REQ-016 SHALL have port overrun_clear, input, 1 bit: clears overrun.
REQ-017 SHALL have port fifo_count, output, $clog2(fifo_depth)+1 bits: the number of stored entries.

Function
REQ-018 SHALL derive bit period P = clk_frequency / baud_rate (integer division); elaboration SHALL fail if P < 8 or if any parameter is outside its legal range.
REQ-019 SHALL synchronise rx through two flops reset to 1 before any use (rx_s).
REQ-020 SHALL have FSM states IDLE, START, DATA, PARITY, STOP; IDLE after reset.
REQ-021 IDLE: a 1->0 transition of rx_s SHALL enter START and load the bit counter so the next sample falls P/2 cycles later (mid start bit).
REQ-022 START sample: rx_s = 1 SHALL be treated as a false start, returning to IDLE with no FIFO write; rx_s = 0 SHALL enter DATA.
REQ-023 Every subsequent sample SHALL occur exactly P cycles after the previous one.
REQ-024 DATA SHALL capture data_bits samples LSB first, then enter PARITY if parity_mode != 0, otherwise STOP.
REQ-025 PARITY: parity_err SHALL be set if XOR(data, sample) != 0 for even, or XOR(data, sample) != 1 for odd.
REQ-026 STOP SHALL take stop_bits samples; frame_err SHALL be set if any stop sample is 0.
REQ-027 On the last stop sample, the FSM SHALL return to IDLE in the same cycle, so a start edge arriving in the second half of the stop bit is detected.
REQ-028 A completed frame SHALL be written to the FIFO as {parity_err, frame_err, data}; out_valid SHALL rise on the cycle after the last stop sample if the FIFO was empty.
REQ-029 FIFO pop SHALL occur when out_valid & out_ready; out_* SHALL present the next entry on the following cycle.
REQ-030 out_data, out_parity_err and out_frame_err SHALL be don't-care while out_valid = 0.
REQ-031 When the FIFO is full with no same-cycle pop, a completed frame SHALL be discarded and overrun set.
REQ-032 When the FIFO is full with a same-cycle pop, the write SHALL be accepted and overrun left unchanged.
REQ-033 A simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-034 Read and write pointers SHALL wrap modulo fifo_depth.
REQ-035 overrun_clear SHALL clear overrun; if a set event occurs in the same cycle, the set SHALL win.
REQ-036 After a framing error with rx held low (break), no new frame SHALL start until rx_s returns to 1 and falls again.

Reset
REQ-037 While reset is asserted: FSM = IDLE, counter = 0, FIFO empty, fifo_count = 0, out_valid = 0, overrun = 0, synchroniser flops = 1.
REQ-038 Reset asserted mid-frame SHALL abort the frame with no FIFO write; the first frame after reset release SHALL require a fresh falling edge.

Verification
REQ-039 Default framing, 0x55 then 0xA3 sent back-to-back with out_ready = 1 -> two pops of 0x55 and 0xA3, both error flags 0.
REQ-040 parity_mode = 1, byte 0x07 sent with parity bit 0 -> entry data 0x07, parity_err = 1; the same byte with parity bit 1 -> parity_err = 0.
REQ-041 A 0.3*P low glitch on rx -> no FIFO write, FSM back in IDLE; the next valid frame is received correctly.
REQ-042 stop_bits = 2, second stop bit driven 0, data 0x3C -> data 0x3C, frame_err = 1.
REQ-043 fifo_depth = 4, out_ready = 0, 5 frames sent -> fifo_count = 4, overrun = 1, pops return frames 1..4.
REQ-044 Reset pulse during the DATA state, then frame 0x81 -> exactly one entry, 0x81, received.

Source files
------------

// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
// uart_rx_fifo: oversampling-free UART receiver (one mid-bit sample per bit)
// feeding a small power-of-two receive FIFO with a sticky overrun flag.
module uart_rx_fifo #(
  parameter int clk_frequency = 50000000,
  parameter int baud_rate     = 115200,
  parameter int data_bits     = 8,
  parameter int parity_mode   = 0,
  parameter int stop_bits     = 1,
  parameter int fifo_depth    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  output logic [data_bits-1:0]          out_data,
  output logic                          out_parity_err,
  output logic                          out_frame_err,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          overrun,
  input  logic                          overrun_clear,
  output logic [$clog2(fifo_depth):0]   fifo_count
);

  localparam int bit_period  = clk_frequency / baud_rate;
  localparam int half_period = bit_period / 2;
  localparam int cnt_w       = $clog2(bit_period);
  localparam int addr_w      = $clog2(fifo_depth);
  localparam int entry_w     = data_bits + 2;
  localparam bit odd_parity  = (parity_mode == 2);
  localparam bit has_parity  = (parity_mode != 0);

  localparam logic [cnt_w-1:0] period_load = cnt_w'(bit_period - 1);
  localparam logic [cnt_w-1:0] half_load   = cnt_w'(half_period - 1);
  localparam logic [3:0]       last_data   = 4'(data_bits - 1);
  localparam logic             last_stop   = 1'(stop_bits - 1);

  // Reject configurations the receiver cannot handle correctly.
  if (bit_period < 8 ||
      data_bits < 5 || data_bits > 9 ||
      parity_mode < 0 || parity_mode > 2 ||
      stop_bits < 1 || stop_bits > 2 ||
      fifo_depth < 2 || (fifo_depth & (fifo_depth - 1)) != 0) begin : g_param_check
    $fatal(1, "uart_rx_fifo: illegal parameter combination");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Receiver state
  state_t               state_q, state_d;
  logic [cnt_w-1:0]     cnt_q, cnt_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [data_bits-1:0] shift_q, shift_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 push;
  logic [entry_w-1:0]   push_word;

  // Synchroniser and start-edge qualification
  logic       rx_meta, rx_s, rx_prev;
  logic [1:0] settle;
  logic       start_edge, sample;

  // FIFO
  logic [entry_w-1:0] mem [fifo_depth];
  logic [addr_w-1:0]  wr_ptr, rd_ptr;
  logic [addr_w:0]    count;
  logic               full, pop, wr_en, overrun_set;

  // Two-flop synchroniser; rx_prev only reports a high line once the
  // synchroniser holds real samples, so a low line at reset release is not an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      settle  <= 2'b00;
      rx_prev <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      settle  <= {settle[0], 1'b1};
      rx_prev <= settle[1] & rx_s;
    end
  end

  assign start_edge = rx_prev & ~rx_s;
  assign sample     = (cnt_q == '0);

  // Receiver state register and frame datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      stop_idx_q   <= 1'b0;
      shift_q      <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      stop_idx_q   <= stop_idx_d;
      shift_q      <= shift_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Next-state logic: one sample per bit when the down-counter hits zero
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    stop_idx_d   = stop_idx_q;
    shift_d      = shift_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    push         = 1'b0;
    push_word    = {parity_err_q, frame_err_q, shift_q};

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d = START;
          cnt_d   = half_load;
        end
      end

      START: begin
        if (sample) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d      = DATA;
            cnt_d        = period_load;
            bit_idx_d    = '0;
            parity_err_d = 1'b0;
            frame_err_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - cnt_w'(1);
        end
      end

      DATA: begin
        if (sample) begin
          shift_d   = {rx_s, shift_q[data_bits-1:1]};
          bit_idx_d = bit_idx_q + 4'd1;
          cnt_d     = period_load;
          if (bit_idx_q == last_data) begin
            state_d    = has_parity ? PARITY : STOP;
            stop_idx_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - cnt_w'(1);
        end
      end

      PARITY: begin
        if (sample) begin
          parity_err_d = (^shift_q) ^ rx_s ^ odd_parity;
          state_d      = STOP;
          stop_idx_d   = 1'b0;
          cnt_d        = period_load;
        end else begin
          cnt_d = cnt_q - cnt_w'(1);
        end
      end

      STOP: begin
        if (sample) begin
          frame_err_d = frame_err_q | ~rx_s;
          if (stop_idx_q == last_stop) begin
            push      = 1'b1;
            push_word = {parity_err_q, frame_err_q | ~rx_s, shift_q};
            state_d   = IDLE;
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
            cnt_d      = period_load;
          end
        end else begin
          cnt_d = cnt_q - cnt_w'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign full        = (count == (addr_w + 1)'(fifo_depth));
  assign out_valid   = (count != '0);
  assign pop         = out_valid & out_ready;
  assign wr_en       = push & (~full | pop);
  assign overrun_set = push & full & ~pop;

  // FIFO storage; contents need no reset because out_valid qualifies them
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_word;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + addr_w'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + addr_w'(1);
      end
      case ({wr_en, pop})
        2'b10:   count <= count + (addr_w + 1)'(1);
        2'b01:   count <= count - (addr_w + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overrun; a drop in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (overrun_set) begin
      overrun <= 1'b1;
    end else if (overrun_clear) begin
      overrun <= 1'b0;
    end
  end

  assign {out_parity_err, out_frame_err, out_data} = mem[rd_ptr];
  assign fifo_count = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
// tb_uart_rx_fifo: three receivers (default framing, even parity, two stop
// bits) on separate serial lines; expected entries are queued as frames are
// driven and compared as the FIFOs present them.
module tb_uart_rx_fifo;

  localparam int clk_hz = 1000000;
  localparam int baud   = 62500;
  localparam int p      = clk_hz / baud;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       rx_d = 1'b1, rdy_d = 1'b0, clr_d = 1'b0;
  logic [7:0] data_d;
  logic       pe_d, fe_d, val_d, ovr_d;
  logic [2:0] cnt_d;

  logic       rx_p = 1'b1, rdy_p = 1'b0, clr_p = 1'b0;
  logic [7:0] data_p;
  logic       pe_p, fe_p, val_p, ovr_p;
  logic [2:0] cnt_p;

  logic       rx_t = 1'b1, rdy_t = 1'b0, clr_t = 1'b0;
  logic [7:0] data_t;
  logic       pe_t, fe_t, val_t, ovr_t;
  logic [2:0] cnt_t;

  int total = 0;
  int bad   = 0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(.clk_frequency(clk_hz), .baud_rate(baud), .data_bits(8),
                 .parity_mode(0), .stop_bits(1), .fifo_depth(4)) u_def (
    .clk(clk), .reset(reset), .rx(rx_d), .out_data(data_d),
    .out_parity_err(pe_d), .out_frame_err(fe_d), .out_valid(val_d),
    .out_ready(rdy_d), .overrun(ovr_d), .overrun_clear(clr_d), .fifo_count(cnt_d));

  uart_rx_fifo #(.clk_frequency(clk_hz), .baud_rate(baud), .data_bits(8),
                 .parity_mode(1), .stop_bits(1), .fifo_depth(4)) u_par (
    .clk(clk), .reset(reset), .rx(rx_p), .out_data(data_p),
    .out_parity_err(pe_p), .out_frame_err(fe_p), .out_valid(val_p),
    .out_ready(rdy_p), .overrun(ovr_p), .overrun_clear(clr_p), .fifo_count(cnt_p));

  uart_rx_fifo #(.clk_frequency(clk_hz), .baud_rate(baud), .data_bits(8),
                 .parity_mode(0), .stop_bits(2), .fifo_depth(4)) u_two (
    .clk(clk), .reset(reset), .rx(rx_t), .out_data(data_t),
    .out_parity_err(pe_t), .out_frame_err(fe_t), .out_valid(val_t),
    .out_ready(rdy_t), .overrun(ovr_t), .overrun_clear(clr_t), .fifo_count(cnt_t));

  task automatic drive_rx(input int sel, input logic v);
    case (sel)
      0:       rx_d = v;
      1:       rx_p = v;
      default: rx_t = v;
    endcase
  endtask

  // Drives one frame LSB first; the line is left at the last stop level.
  task automatic applyStimulus(input int sel, input logic [7:0] data,
                               input bit use_par, input logic par_bit,
                               input logic [1:0] stops, input int nstop);
    @(negedge clk);
    drive_rx(sel, 1'b0);
    repeat (p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive_rx(sel, data[i]);
      repeat (p) @(negedge clk);
    end
    if (use_par) begin
      drive_rx(sel, par_bit);
      repeat (p) @(negedge clk);
    end
    for (int i = 0; i < nstop; i++) begin
      drive_rx(sel, stops[i]);
      repeat (p) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (val_d !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b expected 0", val_d); end
    total++; if (cnt_d !== 3'd0) begin bad++; $display("[TB] FAIL reset_count: got %0d expected 0", cnt_d); end
    total++; if (ovr_d !== 1'b0) begin bad++; $display("[TB] FAIL reset_overrun: got %b expected 0", ovr_d); end
    total++; if (val_p !== 1'b0 || val_t !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid_others: got %b%b expected 00", val_p, val_t); end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (val_d !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_valid: got %b expected 0", val_d); end
  endtask

  task automatic test_back_to_back();
    rdy_d = 1'b1;
    exp_q.push_back({2'b00, 8'h55});
    exp_q.push_back({2'b00, 8'hA3});
    fork
      begin
        applyStimulus(0, 8'h55, 1'b0, 1'b0, 2'b11, 1);
        applyStimulus(0, 8'hA3, 1'b0, 1'b0, 2'b11, 1);
      end
      begin
        for (int i = 0; i < 2; i++) begin
          int waited;
          logic [9:0] exp;
          waited = 0;
          do begin @(posedge clk); #2; waited++; end while (!val_d && waited < 1000);
          exp = exp_q.pop_front();
          total++;
          if (val_d !== 1'b1 || {pe_d, fe_d, data_d} !== exp) begin
            bad++; $display("[TB] FAIL b2b_entry%0d: got valid=%b word=%h expected valid=1 word=%h", i, val_d, {pe_d, fe_d, data_d}, exp);
          end
        end
      end
    join
    repeat (4) @(negedge clk);
    total++; if (cnt_d !== 3'd0) begin bad++; $display("[TB] FAIL b2b_drained: got %0d expected 0", cnt_d); end
  endtask

  task automatic test_parity();
    rdy_p = 1'b1;
    exp_q.push_back({2'b10, 8'h07});
    exp_q.push_back({2'b00, 8'h07});
    fork
      begin
        applyStimulus(1, 8'h07, 1'b1, 1'b0, 2'b11, 1);
        repeat (2 * p) @(negedge clk);
        applyStimulus(1, 8'h07, 1'b1, 1'b1, 2'b11, 1);
      end
      begin
        for (int i = 0; i < 2; i++) begin
          int waited;
          logic [9:0] exp;
          waited = 0;
          do begin @(posedge clk); #2; waited++; end while (!val_p && waited < 1000);
          exp = exp_q.pop_front();
          total++;
          if (val_p !== 1'b1 || {pe_p, fe_p, data_p} !== exp) begin
            bad++; $display("[TB] FAIL parity_entry%0d: got valid=%b word=%h expected valid=1 word=%h", i, val_p, {pe_p, fe_p, data_p}, exp);
          end
        end
      end
    join
  endtask

  task automatic test_glitch();
    rdy_d = 1'b1;
    @(negedge clk);
    rx_d = 1'b0;
    repeat (p * 3 / 10) @(negedge clk);
    rx_d = 1'b1;
    repeat (3 * p) @(negedge clk);
    total++; if (val_d !== 1'b0 || cnt_d !== 3'd0) begin bad++; $display("[TB] FAIL glitch_no_write: got valid=%b count=%0d expected valid=0 count=0", val_d, cnt_d); end
    exp_q.push_back({2'b00, 8'hC3});
    fork
      applyStimulus(0, 8'hC3, 1'b0, 1'b0, 2'b11, 1);
      begin
        int waited;
        logic [9:0] exp;
        waited = 0;
        do begin @(posedge clk); #2; waited++; end while (!val_d && waited < 1000);
        exp = exp_q.pop_front();
        total++;
        if (val_d !== 1'b1 || {pe_d, fe_d, data_d} !== exp) begin
          bad++; $display("[TB] FAIL glitch_next_frame: got valid=%b word=%h expected valid=1 word=%h", val_d, {pe_d, fe_d, data_d}, exp);
        end
      end
    join
  endtask

  task automatic test_stop2();
    rdy_t = 1'b1;
    exp_q.push_back({2'b01, 8'h3C});
    exp_q.push_back({2'b00, 8'h5A});
    fork
      begin
        applyStimulus(2, 8'h3C, 1'b0, 1'b0, 2'b01, 2);
        rx_t = 1'b1;
        repeat (2 * p) @(negedge clk);
        applyStimulus(2, 8'h5A, 1'b0, 1'b0, 2'b11, 2);
      end
      begin
        for (int i = 0; i < 2; i++) begin
          int waited;
          logic [9:0] exp;
          waited = 0;
          do begin @(posedge clk); #2; waited++; end while (!val_t && waited < 1000);
          exp = exp_q.pop_front();
          total++;
          if (val_t !== 1'b1 || {pe_t, fe_t, data_t} !== exp) begin
            bad++; $display("[TB] FAIL stop2_entry%0d: got valid=%b word=%h expected valid=1 word=%h", i, val_t, {pe_t, fe_t, data_t}, exp);
          end
        end
      end
    join
  endtask

  task automatic test_break();
    rdy_d = 1'b1;
    exp_q.push_back({2'b01, 8'h00});
    fork
      begin
        applyStimulus(0, 8'h00, 1'b0, 1'b0, 2'b00, 1);
        repeat (20 * p) @(negedge clk);
      end
      begin
        int waited;
        logic [9:0] exp;
        waited = 0;
        do begin @(posedge clk); #2; waited++; end while (!val_d && waited < 1000);
        exp = exp_q.pop_front();
        total++;
        if (val_d !== 1'b1 || {pe_d, fe_d, data_d} !== exp) begin
          bad++; $display("[TB] FAIL break_entry: got valid=%b word=%h expected valid=1 word=%h", val_d, {pe_d, fe_d, data_d}, exp);
        end
      end
    join
    total++; if (val_d !== 1'b0 || cnt_d !== 3'd0) begin bad++; $display("[TB] FAIL break_no_restart: got valid=%b count=%0d expected valid=0 count=0", val_d, cnt_d); end
    rx_d = 1'b1;
    repeat (2 * p) @(negedge clk);
    exp_q.push_back({2'b00, 8'h96});
    fork
      applyStimulus(0, 8'h96, 1'b0, 1'b0, 2'b11, 1);
      begin
        int waited;
        logic [9:0] exp;
        waited = 0;
        do begin @(posedge clk); #2; waited++; end while (!val_d && waited < 1000);
        exp = exp_q.pop_front();
        total++;
        if (val_d !== 1'b1 || {pe_d, fe_d, data_d} !== exp) begin
          bad++; $display("[TB] FAIL break_recovery: got valid=%b word=%h expected valid=1 word=%h", val_d, {pe_d, fe_d, data_d}, exp);
        end
      end
    join
  endtask

  task automatic test_overrun();
    logic [7:0] frames [5];
    frames[0] = 8'h11; frames[1] = 8'h22; frames[2] = 8'h33; frames[3] = 8'h44; frames[4] = 8'h55;
    rdy_d = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) exp_q.push_back({2'b00, frames[k]});
      applyStimulus(0, frames[k], 1'b0, 1'b0, 2'b11, 1);
      repeat (2 * p) @(negedge clk);
      if (k == 3) begin
        total++; if (cnt_d !== 3'd4 || ovr_d !== 1'b0) begin bad++; $display("[TB] FAIL full_no_overrun: got count=%0d overrun=%b expected count=4 overrun=0", cnt_d, ovr_d); end
      end
    end
    total++; if (cnt_d !== 3'd4) begin bad++; $display("[TB] FAIL overrun_count: got %0d expected 4", cnt_d); end
    total++; if (ovr_d !== 1'b1) begin bad++; $display("[TB] FAIL overrun_flag: got %b expected 1", ovr_d); end
    for (int i = 0; i < 4; i++) begin
      logic [9:0] exp;
      @(posedge clk); #2;
      exp = exp_q.pop_front();
      total++;
      if (val_d !== 1'b1 || {pe_d, fe_d, data_d} !== exp) begin
        bad++; $display("[TB] FAIL overrun_pop%0d: got valid=%b word=%h expected valid=1 word=%h", i, val_d, {pe_d, fe_d, data_d}, exp);
      end
      @(negedge clk); rdy_d = 1'b1;
      @(negedge clk); rdy_d = 1'b0;
    end
    total++; if (val_d !== 1'b0 || ovr_d !== 1'b1) begin bad++; $display("[TB] FAIL overrun_sticky: got valid=%b overrun=%b expected valid=0 overrun=1", val_d, ovr_d); end
    @(negedge clk); clr_d = 1'b1;
    @(negedge clk); clr_d = 1'b0;
    total++; if (ovr_d !== 1'b0) begin bad++; $display("[TB] FAIL overrun_clear: got %b expected 0", ovr_d); end
  endtask

  task automatic test_reset_mid_frame();
    rdy_d = 1'b1;
    fork
      applyStimulus(0, 8'hF0, 1'b0, 1'b0, 2'b11, 1);
      begin
        repeat (3 * p) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
      end
    join
    repeat (2 * p) @(negedge clk);
    total++; if (val_d !== 1'b0 || cnt_d !== 3'd0) begin bad++; $display("[TB] FAIL abort_no_write: got valid=%b count=%0d expected valid=0 count=0", val_d, cnt_d); end
    exp_q.push_back({2'b00, 8'h81});
    fork
      applyStimulus(0, 8'h81, 1'b0, 1'b0, 2'b11, 1);
      begin
        int waited;
        logic [9:0] exp;
        waited = 0;
        do begin @(posedge clk); #2; waited++; end while (!val_d && waited < 1000);
        exp = exp_q.pop_front();
        total++;
        if (val_d !== 1'b1 || {pe_d, fe_d, data_d} !== exp) begin
          bad++; $display("[TB] FAIL after_reset_frame: got valid=%b word=%h expected valid=1 word=%h", val_d, {pe_d, fe_d, data_d}, exp);
        end
      end
    join
    repeat (2 * p) @(negedge clk);
    total++; if (val_d !== 1'b0 || cnt_d !== 3'd0) begin bad++; $display("[TB] FAIL after_reset_single: got valid=%b count=%0d expected valid=0 count=0", val_d, cnt_d); end
  endtask

  // Runs every scenario in order and reports the totals.
  initial begin
    $display("[TB] starting uart_rx_fifo bench, bit period %0d clocks", p);
    test_reset();
    test_back_to_back();
    test_parity();
    test_glitch();
    test_stop2();
    test_break();
    test_overrun();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
